col_feeder: RTL and testbench
=============================

COL_FEEDER -- requirements
Module: col_feeder

Interface
REQ-001 SHALL have parameter NB, default 17, width of the column word stream (B_out).
REQ-002 SHALL have parameter NID, default 7, width of the row-index field in weight words.
REQ-003 SHALL have parameter ROWS, default 16, number of PE rows fed; 1..2^NID.
REQ-004 SHALL have port clk  input  1  single clock, rising edge.
REQ-005 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port cmd_valid  input  1  command request.
REQ-007 SHALL have port cmd_ready  output  1  command accept; high only in IDLE.
REQ-008 SHALL have port cmd_op  input  2  00=reset, 01=load weights, 10=multiply, 11=reserved.
REQ-009 SHALL have port w_vec  input  ROWS  binary weights; bit k is row k, sampled at command accept.
REQ-010 SHALL have port n_beats  input  16  bias beat count for multiply, sampled at accept.
REQ-011 SHALL have ports bias_valid, bias_ready (input/output, 1) and bias_in (input, 16), fp16 bias stream.
REQ-012 SHALL have port B_out  output  NB  word into top PE of the column.
REQ-013 SHALL have port done  output  1  one-cycle pulse when a command sequence completes.

Function
REQ-014 Word formats SHALL be: control {1,0..,CMD[3:1],0}; weight {1,0..,IDX[NID+3:4],CMD=000,W[0]}; data {0,fp16[15:0]}.
REQ-015 CMD codes SHALL be: 1 reset, 2 alt2/done, 4 load, 5 mult (NB=17: 0x10002, 0x10004, 0x10008, 0x1000A).
REQ-016 A command SHALL be accepted on cycle T when cmd_valid&&cmd_ready; its first word SHALL appear on B_out at T+1.
REQ-017 B_out SHALL be registered; in IDLE it SHALL be 0.
REQ-018 States SHALL be IDLE, RST, LCMD, LWGT, MCMD, MSTR, MEND.
REQ-019 reset op: IDLE->RST, emit reset word one cycle, return to IDLE.
REQ-020 load op: IDLE->LCMD (emit load word)->LWGT (emit ROWS weight words)->IDLE.
REQ-021 Weight words SHALL be emitted in descending index order ROWS-1..0, one per cycle, W=w_vec[idx] (captured rows stop forwarding, so deepest first is mandatory).
REQ-022 multiply op: IDLE->MCMD (emit mult word)->MSTR->MEND (emit alt2 word)->IDLE.
REQ-023 In MSTR bias_ready SHALL be 1; each accepted beat SHALL emit {0,bias_in} next cycle; a non-valid cycle SHALL emit 0 (bubble, +0.0 bias) and not count.
REQ-024 MSTR SHALL leave after exactly n_beats accepted beats; n_beats=0 SHALL go MCMD->MEND directly.
REQ-025 bias_ready SHALL be 0 outside MSTR.
REQ-026 done SHALL pulse in the cycle the final word (reset, last weight, alt2) is on B_out; cmd_ready SHALL be high the following cycle.
REQ-027 op 11 SHALL be accepted and dropped: no words, no done.
REQ-028 cmd_valid while busy SHALL be ignored (cmd_ready low); no queuing.

Reset
REQ-029 rstn low SHALL immediately force IDLE, B_out=0, done=0, bias_ready=0, cmd_ready=1 after release, counters 0.
REQ-030 Reset mid-sequence SHALL abort it without emitting further words; software re-issues a reset op to clear PEs.

Configuration
REQ-031 With COL_FEEDER_STALL_CNT_EN defined: output stall_cnt (16) counts MSTR bubble cycles, saturating at 0xFFFF, cleared at each multiply accept and by rstn.
REQ-032 Without COL_FEEDER_STALL_CNT_EN: no stall_cnt port, logic absent, all other behaviour identical.

Verification
REQ-033 rstn low mid-LWGT -> B_out=0 same cycle, IDLE, cmd_ready=1 after release.
REQ-034 ROWS=16, load, w_vec=0x8001 -> 0x10008, then 0x100F1, 0x100E0..0x10010, 0x10001; done with last word.
REQ-035 multiply n_beats=3, bias 0x3C00,0x4000,0xC000, one bias_valid gap -> 0x1000A, 0x03C00, 0x04000, 0, 0x0C000, 0x10004; stall_cnt=1 if enabled.
REQ-036 multiply n_beats=0 -> 0x1000A, 0x10004, done; bias_ready never high.
REQ-037 reset op -> single 0x10002, done same cycle; op 11 -> B_out stays 0, no done.
REQ-038 cmd_valid held during load -> second command accepted only the cycle after done.

Source files
------------

// File: rtl/col_feeder.sv
// col_feeder: serialises reset/load/multiply command sequences into the column word stream.
// Optional COL_FEEDER_STALL_CNT_EN adds a saturating count of multiply-stream bubble cycles.
module col_feeder #(
  parameter int NB   = 17,
  parameter int NID  = 7,
  parameter int ROWS = 16
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [ROWS-1:0] w_vec,
  input  logic [15:0]     n_beats,
  input  logic            bias_valid,
  output logic            bias_ready,
  input  logic [15:0]     bias_in,
  output logic [NB-1:0]   B_out,
  output logic            done
`ifdef COL_FEEDER_STALL_CNT_EN
  ,
  output logic [15:0]     stall_cnt
`endif
);
  typedef enum logic [2:0] {IDLE, RST, LCMD, LWGT, MCMD, MSTR, MEND} state_t;
  state_t          state_q;
  logic [NID-1:0]  idx_q;
  logic [ROWS-1:0] w_q;
  logic [15:0]     cnt_q;
  logic [NB-1:0]   b_q;
  logic            done_q;

  function automatic logic [NB-1:0] ctl(input logic [2:0] c);
    return {1'b1, {(NB-5){1'b0}}, c, 1'b0};
  endfunction

  function automatic logic [NB-1:0] wgt(input logic [NID-1:0] i, input logic w);
    return {1'b1, {(NB-NID-5){1'b0}}, i, 3'b000, w};
  endfunction

  assign cmd_ready  = state_q == IDLE;
  // MSTR lingers one cycle with cnt_q==0 while the last beat is on B_out
  assign bias_ready = state_q == MSTR && cnt_q != '0;
  assign B_out      = b_q;
  assign done       = done_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      idx_q   <= '0;
      w_q     <= '0;
      cnt_q   <= '0;
      b_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      b_q    <= '0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (cmd_valid) begin
          w_q   <= w_vec;
          cnt_q <= n_beats;
          case (cmd_op)
            2'b00: begin state_q <= RST; b_q <= ctl(3'd1); done_q <= 1'b1; end
            2'b01: begin state_q <= LCMD; b_q <= ctl(3'd4); end
            2'b10: begin state_q <= n_beats == '0 ? MCMD : MSTR; b_q <= ctl(3'd5); end
            default: ;
          endcase
        end
        // weights leave deepest row first; w_q shifts so its MSB is always the row on deck
        LCMD: begin
          state_q <= LWGT;
          idx_q   <= NID'(ROWS-1);
          b_q     <= wgt(NID'(ROWS-1), w_q[ROWS-1]);
          w_q     <= w_q << 1;
          done_q  <= ROWS == 1;
        end
        LWGT: if (idx_q == '0) state_q <= IDLE;
        else begin
          idx_q  <= idx_q - NID'(1);
          b_q    <= wgt(idx_q - NID'(1), w_q[ROWS-1]);
          w_q    <= w_q << 1;
          done_q <= idx_q == NID'(1);
        end
        MCMD: begin state_q <= MEND; b_q <= ctl(3'd2); done_q <= 1'b1; end
        MSTR: if (cnt_q == '0) begin
          state_q <= MEND;
          b_q     <= ctl(3'd2);
          done_q  <= 1'b1;
        end else if (bias_valid) begin
          b_q   <= {{(NB-16){1'b0}}, bias_in};
          cnt_q <= cnt_q - 16'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef COL_FEEDER_STALL_CNT_EN
  logic [15:0] stall_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) stall_q <= '0;
    else if (cmd_ready && cmd_valid && cmd_op == 2'b10) stall_q <= '0;
    else if (bias_ready && !bias_valid && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
  end
  assign stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_col_feeder.sv
// tb_col_feeder: directed tables, corner sequences and random commands against a word-queue model.
module tb_col_feeder;
  localparam int NB = 17, NID = 7, ROWS = 16;
  logic            clk = 0, rstn = 0, cmd_valid = 0, bias_valid = 0;
  logic [1:0]      cmd_op = 0;
  logic [ROWS-1:0] w_vec = 0;
  logic [15:0]     n_beats = 0, bias_in = 0;
  logic            cmd_ready, bias_ready, done;
  logic [NB-1:0]   B_out;
`ifdef COL_FEEDER_STALL_CNT_EN
  logic [15:0]     stall_cnt;
`endif

  always #5 clk = ~clk;

  col_feeder #(.NB(NB), .NID(NID), .ROWS(ROWS)) dut (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .w_vec(w_vec), .n_beats(n_beats), .bias_valid(bias_valid), .bias_ready(bias_ready),
    .bias_in(bias_in), .B_out(B_out), .done(done)
`ifdef COL_FEEDER_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference: current word, busy flag, pending word queue, and beats still owed by a stream
  int m_cur, m_rem, m_stall;
  bit m_done, m_busy, m_str;
  int q_w[$];
  bit q_d[$];

  function automatic int ctl(int c);
    return (1 << (NB-1)) | (c << 1);
  endfunction

  function automatic int wgt(int i, bit w);
    return (1 << (NB-1)) | (i << 4) | int'(w);
  endfunction

  task automatic mreset();
    m_cur = 0; m_rem = 0; m_stall = 0; m_done = 0; m_busy = 0; m_str = 0;
    q_w.delete(); q_d.delete();
  endtask

  task automatic cyc();
    int n_cur = 0, n_rem = m_rem;
    bit n_done = 0, n_busy = m_busy, n_str = m_str;
    if (!m_busy && cmd_valid) begin
      case (cmd_op)
        2'd0: begin n_cur = ctl(1); n_done = 1; n_busy = 1; end
        2'd1: begin
          n_cur = ctl(4); n_busy = 1;
          for (int i = ROWS-1; i >= 0; i--) begin q_w.push_back(wgt(i, w_vec[i])); q_d.push_back(i == 0); end
        end
        2'd2: begin n_cur = ctl(5); n_busy = 1; n_str = 1; n_rem = int'(n_beats); m_stall = 0; end
        default: n_busy = 0;
      endcase
    end else if (m_str) begin
      if (m_rem > 0) begin
        if (!bias_valid && m_stall < 65535) m_stall++;
        n_cur = bias_valid ? int'(bias_in) : 0;
        if (bias_valid) n_rem--;
      end else begin
        n_cur = ctl(2); n_done = 1; n_str = 0;
      end
    end else if (q_w.size() > 0) begin
      n_cur = q_w.pop_front(); n_done = q_d.pop_front();
    end else n_busy = 0;
    @(posedge clk); #1;
    m_cur = n_cur; m_done = n_done; m_busy = n_busy; m_str = n_str; m_rem = n_rem;
    chk("b_out", 32'(B_out), 32'(m_cur));
    chk("done", 32'(done), 32'(m_done));
    chk("cmd_ready", 32'(cmd_ready), 32'(!m_busy));
    chk("bias_ready", 32'(bias_ready), 32'(m_str && m_rem > 0));
`ifdef COL_FEEDER_STALL_CNT_EN
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
  endtask

  task automatic issue(input logic [1:0] op, input logic [ROWS-1:0] w, input logic [15:0] n);
    cmd_valid = 1; cmd_op = op; w_vec = w; n_beats = n;
    cyc();
    cmd_valid = 0;
  endtask

  task automatic wait_idle(input int budget, input int pv, input bit noise);
    int k = 0;
    while (!cmd_ready && k < budget) begin
      bias_valid = $urandom_range(0, 99) < pv;
      bias_in = 16'($urandom);
      if (noise) begin cmd_valid = 1'($urandom); cmd_op = 2'($urandom); end
      cyc();
      k++;
    end
    cmd_valid = 0;
    chk("idle_timeout", 32'(cmd_ready), 32'd1);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [15:0] w;
    logic [15:0] n;
    int          first;
    int          len;
  } vec_t;

  initial begin
    vec_t tbl[6];
    int len, ex[18];
    logic [16:0] ee[5];
    logic [15:0] bb[5];
    bit vv[5];
    tbl[0] = '{2'd0, 16'h0000, 16'd0, 'h10002, 1};
    tbl[1] = '{2'd1, 16'hA5C3, 16'd0, 'h10008, 17};
    tbl[2] = '{2'd2, 16'h0000, 16'd0, 'h1000A, 2};
    tbl[3] = '{2'd2, 16'h0000, 16'd4, 'h1000A, 6};
    tbl[4] = '{2'd3, 16'hFFFF, 16'd5, 0, 0};
    tbl[5] = '{2'd2, 16'h1234, 16'd1, 'h1000A, 3};
    mreset();

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_b_out", 32'(B_out), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_bias_ready", 32'(bias_ready), 0);
    #2 rstn = 1;
    cyc();

    foreach (tbl[i]) begin
      issue(tbl[i].op, tbl[i].w, tbl[i].n);
      chk("tbl_first", 32'(B_out), 32'(tbl[i].first));
      len = 0;
      while (!cmd_ready && len < 100) begin
        bias_valid = 1; bias_in = 16'($urandom);
        cyc();
        len++;
      end
      chk("tbl_len", 32'(len), 32'(tbl[i].len));
      cyc();
    end

    // load w_vec=0x8001: exact word list, done on the last weight
    ex[0] = 'h10008; ex[1] = 'h100F1; ex[16] = 'h10001;
    for (int i = 14; i >= 1; i--) ex[16-i] = 'h10000 | (i << 4);
    issue(2'd1, 16'h8001, 16'd0);
    chk("ld_word", 32'(B_out), 32'(ex[0]));
    for (int i = 1; i <= 16; i++) begin
      cyc();
      chk("ld_word", 32'(B_out), 32'(ex[i]));
      chk("ld_done", 32'(done), 32'(i == 16));
    end
    cyc();
    chk("ld_ready_after", 32'(cmd_ready), 1);

    // multiply with one bias gap
    vv = '{1, 1, 0, 1, 0};
    bb = '{16'h3C00, 16'h4000, 16'h1111, 16'hC000, 16'h0};
    ee = '{17'h03C00, 17'h04000, 17'h0, 17'h0C000, 17'h10004};
    issue(2'd2, 16'h0, 16'd3);
    chk("mul_word", 32'(B_out), 'h1000A);
    for (int i = 0; i < 5; i++) begin
      bias_valid = vv[i]; bias_in = bb[i];
      cyc();
      chk("mul_word", 32'(B_out), 32'(ee[i]));
    end
    chk("mul_done", 32'(done), 1);
`ifdef COL_FEEDER_STALL_CNT_EN
    chk("mul_stall", 32'(stall_cnt), 1);
`endif
    cyc();

    // multiply with zero beats
    bias_valid = 1;
    issue(2'd2, 16'h0, 16'd0);
    chk("m0_word", 32'(B_out), 'h1000A);
    chk("m0_bias_ready", 32'(bias_ready), 0);
    cyc();
    chk("m0_word", 32'(B_out), 'h10004);
    chk("m0_done", 32'(done), 1);
    chk("m0_bias_ready", 32'(bias_ready), 0);
    bias_valid = 0;
    cyc();

    // reset op then reserved op
    issue(2'd0, 16'h0, 16'd0);
    chk("rop_word", 32'(B_out), 'h10002);
    chk("rop_done", 32'(done), 1);
    cyc();
    issue(2'd3, 16'hFFFF, 16'd3);
    for (int i = 0; i < 3; i++) begin
      chk("op3_b_out", 32'(B_out), 0);
      chk("op3_done", 32'(done), 0);
      cyc();
    end

    // async reset in the middle of weight emission
    issue(2'd1, 16'hBEEF, 16'd0);
    repeat (5) cyc();
    #2 rstn = 0;
    #1;
    chk("mid_rst_b_out", 32'(B_out), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_ready", 32'(cmd_ready), 1);
    mreset();
    @(posedge clk); #1;
    rstn = 1;
    cyc();
    chk("post_rst_b_out", 32'(B_out), 0);

    // held cmd_valid: second load accepted only the cycle after done
    cmd_valid = 1; cmd_op = 2'd1; w_vec = 16'h00FF;
    cyc();
    len = 0;
    while (!done && len < 40) begin cyc(); len++; end
    chk("hold_done_seen", 32'(done), 1);
    cyc();
    chk("hold_ready", 32'(cmd_ready), 1);
    chk("hold_gap", 32'(B_out), 0);
    cyc();
    chk("hold_second", 32'(B_out), 'h10008);
    cmd_valid = 0;
    wait_idle(40, 100, 0);

    // random commands with noise on cmd_valid while busy
    for (int t = 0; t < 40; t++) begin
      issue(2'($urandom), ROWS'($urandom), 16'($urandom_range(0, 6)));
      wait_idle(100, 70, 1);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
